// File: rtl/booth_div_seq.sv
`timescale 1ns/1ps
// booth_div_seq -- sequential signed restoring divider.
//
// Divides a 2*TAM-bit signed dividend by a TAM-bit signed divisor and returns
// a quotient truncated toward zero plus a remainder whose sign follows the
// dividend. Every operation takes the same number of cycles, including the
// divide-by-zero and overflow cases: one PREP cycle, TAM CALC cycles and one
// FIX cycle after the accept edge.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request, sampled only while idle
//   N      2*TAM-bit signed dividend
//   D      TAM-bit signed divisor
//   Q      TAM-bit signed quotient (truncated toward zero)
//   R      TAM-bit signed remainder (sign of N, |R| < |D|)
//   busy   high while a division is in flight
//   done   one-cycle pulse when Q/R/dz/ovf are updated
//   dz     divide-by-zero flag for the last result
//   ovf    quotient-overflow flag for the last result
module booth_div_seq #(
  parameter int TAM = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic signed [2*TAM-1:0] N,
  input  logic signed [TAM-1:0]   D,
  output logic signed [TAM-1:0]   Q,
  output logic signed [TAM-1:0]   R,
  output logic                    busy,
  output logic                    done,
  output logic                    dz,
  output logic                    ovf
);

  localparam int CW = $clog2(TAM) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX
  } state_t;

  state_t r_state;
  state_t w_next;

  // Latched operands
  logic signed [2*TAM-1:0] r_n;
  logic signed [TAM-1:0]   r_d;

  // Division working state
  logic [TAM-1:0] r_dabs;
  logic [TAM:0]   r_rem;   // partial remainder, one guard bit wide
  logic [TAM-1:0] r_lo;    // low dividend bits shift out, quotient bits shift in
  logic [CW-1:0]  r_cnt;
  logic           r_sq;
  logic           r_sr;
  logic           r_zero;
  logic           r_pre;

  // Result registers
  logic [TAM-1:0] r_q;
  logic [TAM-1:0] r_r;
  logic           r_done;
  logic           r_dz;
  logic           r_ovf;

  logic [2*TAM-1:0] w_nabs;
  logic [TAM-1:0]   w_dabs;
  logic [TAM+1:0]   w_diff;
  logic             w_qbit;
  logic             w_ovf;

  // Two's-complement sign application to an unsigned magnitude.
  function automatic logic [TAM-1:0] f_apply_sign(input logic [TAM-1:0] mag,
                                                  input logic           neg);
    return neg ? (~mag + 1'b1) : mag;
  endfunction

  // Quotient range check: positive results must stay below 2^(TAM-1),
  // negative results may reach exactly 2^(TAM-1).
  function automatic logic f_q_overflow(input logic [TAM-1:0] mag,
                                        input logic           neg,
                                        input logic           pre);
    logic w_big;
    w_big = neg ? (mag[TAM-1] & (|mag[TAM-2:0])) : mag[TAM-1];
    return pre | w_big;
  endfunction

  // Magnitudes: the most negative values map onto their exact unsigned
  // magnitude because the negation result is read back as unsigned.
  assign w_nabs = r_n[2*TAM-1] ? (~r_n + 1'b1) : r_n;
  assign w_dabs = r_d[TAM-1]   ? (~r_d + 1'b1) : r_d;

  // Trial subtract over TAM+2 bits so |D| = 2^(TAM-1) never wraps.
  assign w_diff = {r_rem, r_lo[TAM-1]} - {2'b00, r_dabs};
  assign w_qbit = ~w_diff[TAM+1];

  assign w_ovf = f_q_overflow(r_lo, r_sq, r_pre);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = S_PREP;
      S_PREP: w_next = S_CALC;
      S_CALC: if (r_cnt == CW'(TAM - 1)) w_next = S_FIX;
      S_FIX:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n    <= '0;
      r_d    <= '0;
      r_dabs <= '0;
      r_rem  <= '0;
      r_lo   <= '0;
      r_cnt  <= '0;
      r_sq   <= 1'b0;
      r_sr   <= 1'b0;
      r_zero <= 1'b0;
      r_pre  <= 1'b0;
      r_q    <= '0;
      r_r    <= '0;
      r_done <= 1'b0;
      r_dz   <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        // Accept: operands are frozen here, later input changes are ignored
        S_IDLE: begin
          if (start) begin
            r_n <= N;
            r_d <= D;
          end
        end
        // Prepare magnitudes, signs and the early overflow test
        S_PREP: begin
          r_dabs <= w_dabs;
          r_sq   <= r_n[2*TAM-1] ^ r_d[TAM-1];
          r_sr   <= r_n[2*TAM-1];
          r_zero <= (r_d == '0);
          r_pre  <= (w_nabs[2*TAM-1:TAM] >= w_dabs);
          r_rem  <= {1'b0, w_nabs[2*TAM-1:TAM]};
          r_lo   <= w_nabs[TAM-1:0];
          r_cnt  <= '0;
        end
        // One restoring step per cycle
        S_CALC: begin
          r_rem <= w_qbit ? w_diff[TAM:0] : {r_rem[TAM-1:0], r_lo[TAM-1]};
          r_lo  <= {r_lo[TAM-2:0], w_qbit};
          r_cnt <= r_cnt + 1'b1;
        end
        // Sign fix-up, error substitution and result publish
        S_FIX: begin
          r_done <= 1'b1;
          if (r_zero) begin
            r_dz  <= 1'b1;
            r_ovf <= 1'b0;
            r_q   <= '1;
            r_r   <= r_n[TAM-1:0];
          end else if (w_ovf) begin
            r_dz  <= 1'b0;
            r_ovf <= 1'b1;
            r_q   <= '0;
            r_r   <= '0;
          end else begin
            r_dz  <= 1'b0;
            r_ovf <= 1'b0;
            r_q   <= f_apply_sign(r_lo, r_sq);
            r_r   <= f_apply_sign(r_rem[TAM-1:0], r_sr);
          end
        end
        default: ;
      endcase
    end
  end

  assign Q    = r_q;
  assign R    = r_r;
  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign dz   = r_dz;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_booth_div_seq.sv
`timescale 1ns/1ps
// Bench for booth_div_seq at TAM=8: an arithmetic reference model predicts
// each result and its done cycle; one compare process checks every cycle.
module tb_booth_div_seq;

  localparam int TAM = 8;
  localparam int LAT = TAM + 2;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [2*TAM-1:0] N   = '0;
  logic [TAM-1:0]   D   = '0;
  logic [TAM-1:0]   Q;
  logic [TAM-1:0]   R;
  logic           busy;
  logic           done;
  logic           dz;
  logic           ovf;

  booth_div_seq #(.TAM(TAM)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .N    (N),
    .D    (D),
    .Q    (Q),
    .R    (R),
    .busy (busy),
    .done (done),
    .dz   (dz),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: accepts are counted by the posedge process, completions by
  // the compare process; a division is pending while the two differ.
  int cyc    = 0;
  int n_acc  = 0;
  int n_done = 0;
  int e_due  = 0;
  logic [2*TAM+1:0] e_res = '0;

  // Held (last published) expectations
  logic [TAM-1:0] h_q = '0;
  logic [TAM-1:0] h_r = '0;
  logic           h_z = 1'b0;
  logic           h_o = 1'b0;

  // Hand-computed literal expectations that pin the model
  logic           x_en = 1'b0;
  logic [TAM-1:0] x_q  = '0;
  logic [TAM-1:0] x_r  = '0;
  logic           x_z  = 1'b0;
  logic           x_o  = 1'b0;

  // Reference: plain integer division, truncating toward zero.
  function automatic logic [2*TAM+1:0] f_model(input logic [2*TAM-1:0] n,
                                               input logic [TAM-1:0]   d);
    longint sn;
    longint sd;
    longint qq;
    longint rr;
    logic [TAM-1:0] q;
    logic [TAM-1:0] r;
    logic z;
    logic o;
    sn = longint'($signed(n));
    sd = longint'($signed(d));
    q = '0; r = '0; z = 1'b0; o = 1'b0;
    if (sd == 0) begin
      z = 1'b1;
      q = '1;
      r = n[TAM-1:0];
    end else begin
      qq = sn / sd;
      rr = sn % sd;
      if (qq > longint'(2**(TAM-1) - 1) || qq < -longint'(2**(TAM-1))) begin
        o = 1'b1;
      end else begin
        q = qq[TAM-1:0];
        r = rr[TAM-1:0];
      end
    end
    return {q, r, z, o};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: accept on a rising edge when idle with start high.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst_n && start && (n_acc == n_done)) begin
      e_res = f_model(N, D);
      e_due = cyc + LAT;
      n_acc++;
    end
  end

  // Compare process
  initial forever begin
    @(negedge clk or negedge rst_n);
    if (!rst_n) begin
      #1;
      n_done = n_acc;
      h_q = '0; h_r = '0; h_z = 1'b0; h_o = 1'b0;
      chk("rst_Q",    32'(Q),    32'd0);
      chk("rst_R",    32'(R),    32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_dz",   32'(dz),   32'd0);
      chk("rst_ovf",  32'(ovf),  32'd0);
    end else begin
      logic pend;
      logic exp_done;
      pend     = (n_acc != n_done);
      exp_done = pend && (cyc == e_due);
      chk("done", 32'(done), 32'(exp_done));
      chk("busy", 32'(busy), 32'(pend && (cyc < e_due)));
      if (exp_done) begin
        {h_q, h_r, h_z, h_o} = e_res;
        n_done = n_acc;
        if (x_en) begin
          chk("lit_Q",   32'(h_q), 32'(x_q));
          chk("lit_R",   32'(h_r), 32'(x_r));
          chk("lit_dz",  32'(h_z), 32'(x_z));
          chk("lit_ovf", 32'(h_o), 32'(x_o));
        end
      end
      chk("Q",   32'(Q),   32'(h_q));
      chk("R",   32'(R),   32'(h_r));
      chk("dz",  32'(dz),  32'(h_z));
      chk("ovf", 32'(ovf), 32'(h_o));
    end
  end

  task automatic wait_done();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 4 * TAM && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      $display("FAIL done_timeout: got no done within %0d cycles, required one", 4 * TAM);
      $fatal(1, "timeout");
    end
  endtask

  task automatic run_op(input logic [2*TAM-1:0] n, input logic [TAM-1:0] d,
                        input logic lit, input logic [TAM-1:0] q,
                        input logic [TAM-1:0] r, input logic z, input logic o);
    @(posedge clk); #1;
    x_en = lit; x_q = q; x_r = r; x_z = z; x_o = o;
    start = 1'b1; N = n; D = d;
    @(posedge clk); #1;
    start = 1'b0;
    N = 16'($urandom);
    D = 8'($urandom);
    wait_done();
    @(posedge clk); #1;
    x_en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [TAM-1:0]   a8;
    logic [TAM-1:0]   b8;
    logic [2*TAM-1:0] n16;
    int               p;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    run_op(16'd100,   8'd7,   1'b1, 8'h0E, 8'h02, 1'b0, 1'b0);
    run_op(16'hFF9C,  8'd7,   1'b1, 8'hF2, 8'hFE, 1'b0, 1'b0);
    run_op(16'd100,   8'hF9,  1'b1, 8'hF2, 8'h02, 1'b0, 1'b0);
    run_op(16'hC000,  8'h80,  1'b1, 8'h00, 8'h00, 1'b0, 1'b1);
    run_op(16'hC000,  8'h7F,  1'b1, 8'h00, 8'h00, 1'b0, 1'b1);
    run_op(16'h3F80,  8'h80,  1'b1, 8'h81, 8'h00, 1'b0, 1'b0);
    run_op(16'h4000,  8'h80,  1'b1, 8'h80, 8'h00, 1'b0, 1'b0);
    run_op(16'h1234,  8'h00,  1'b1, 8'hFF, 8'h34, 1'b1, 1'b0);
    run_op(16'h8000,  8'hFF,  1'b1, 8'h00, 8'h00, 1'b0, 1'b1);

    // start pulsed while busy must be ignored
    @(posedge clk); #1;
    start = 1'b1; N = 16'd1000; D = 8'd13;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 start = 1'b1; N = 16'd5; D = 8'd1;
    @(posedge clk); #1 start = 1'b0;
    wait_done();
    repeat (LAT + 3) @(posedge clk);

    // start held through done: second op accepted on the done cycle
    @(posedge clk); #1;
    start = 1'b1; N = 16'd256; D = 8'd3;
    @(posedge clk); #1;
    N = 16'hFE0C; D = 8'd9;
    wait_done();
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
    repeat (3) @(posedge clk);

    // reset in the middle of CALC aborts without a done
    @(posedge clk); #1;
    start = 1'b1; N = 16'd1000; D = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (LAT + 4) @(posedge clk);
    run_op(16'd100, 8'd7, 1'b1, 8'h0E, 8'h02, 1'b0, 1'b0);

    // round trip: N = A*B divided by A
    for (int i = 0; i < 1500; i++) begin
      a8 = 8'($urandom);
      if (a8 == '0) a8 = 8'd1;
      b8 = 8'($urandom);
      if (i == 0) begin a8 = 8'hFF; b8 = 8'h80; end
      if (i == 1) begin a8 = 8'h80; b8 = 8'h80; end
      p   = int'($signed(a8)) * int'($signed(b8));
      n16 = p[2*TAM-1:0];
      run_op(n16, a8, 1'b0, '0, '0, 1'b0, 1'b0);
    end

    // general random operands, including small dividends and zero divisors
    for (int i = 0; i < 600; i++) begin
      n16 = 16'($urandom);
      if (i % 2 == 1) n16 = {{TAM{n16[TAM-1]}}, n16[TAM-1:0]};
      a8 = 8'($urandom);
      if (i % 37 == 0) a8 = '0;
      run_op(n16, a8, 1'b0, '0, '0, 1'b0, 1'b0);
    end

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
